// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared definitions for the RAM write/read-back controller.
//   state_e    controller FSM states
//   DEPTH      word count of the default-sized RAM (2**BIST_ADDR_W)
//   pat()      expected/written word for an address, offset and inversion bit
// Build option: RAM_BIST_AUTO_EN (see ram_bist_ctrl) uses the inv argument.
package ram_bist_pkg;

  localparam int unsigned BIST_ADDR_W = 5;
  localparam int unsigned BIST_DATA_W = 8;
  localparam int unsigned DEPTH       = 2 ** BIST_ADDR_W;

  // pat() works at a fixed wide width; callers truncate to their DATA_W,
  // which keeps the result identical to a mod-2^DATA_W add/invert.
  localparam int unsigned PAT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic [PAT_W-1:0] pat(input logic [PAT_W-1:0] addr,
                                           input logic [PAT_W-1:0] ofs,
                                           input logic             inv);
    logic [PAT_W-1:0] w;
    w = addr + ofs;
    return inv ? ~w : w;
  endfunction

endpackage

// File: rtl/ram_bist_exp_pipe.sv
// ram_bist_exp_pipe: DEPTH-stage shift register of {valid, expected word},
// keeping expected read data aligned with the RAM read latency.
//   clk_i   clock (rising edge)
//   rst_ni  asynchronous active-low clear
//   vld_i   valid bit pushed in each cycle
//   exp_i   expected word pushed in each cycle
//   vld_o   valid bit at the pipe output
//   exp_o   expected word at the pipe output
module ram_bist_exp_pipe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] exp_i,
  output logic              vld_o,
  output logic [DATA_W-1:0] exp_o
);

  logic [DEPTH-1:0]             vld_q;
  logic [DEPTH-1:0][DATA_W-1:0] exp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      exp_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      exp_q[0] <= exp_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        exp_q[i] <= exp_q[i-1];
      end
    end
  end

  assign vld_o = vld_q[DEPTH-1];
  assign exp_o = exp_q[DEPTH-1];

endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: write/read-back exerciser for a single-port RAM.
// Writes pat(addr) to every address, reads every address back and compares
// against the expected value delivered by ram_bist_exp_pipe.
//   sys_clk    system clock (rising edge)
//   sys_rst_n  asynchronous active-low reset
//   start      request a pass (sampled only in IDLE)
//   ena/wea    RAM enable / write enable (registered)
//   addra      RAM address (registered)
//   dina       RAM write data (registered, holds outside WRITE)
//   douta      RAM read data
//   busy       high for WRITE, READ and DRAIN
//   done       one-cycle pulse at the end of a pass
//   err        mismatch flag for the current/last pass
//   err_cnt    mismatching words in the current/last pass
// Build option RAM_BIST_AUTO_EN: free-running passes, start ignored, odd
// passes use the inverted pattern, err sticky until reset.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int unsigned       ADDR_W   = BIST_ADDR_W,
  parameter int unsigned       DATA_W   = BIST_DATA_W,
  parameter int unsigned       RD_LAT   = 1,
  parameter logic [DATA_W-1:0] DATA_OFS = '0
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   err_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
  localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(RD_LAT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ena_q, ena_d;
  logic                wea_q, wea_d;
  logic [ADDR_W-1:0]   addra_q, addra_d;
  logic [DATA_W-1:0]   dina_q, dina_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rdv_q, rdv_d;
  logic [DATA_W-1:0]   rexp_q, rexp_d;
  logic                inv_q, inv_d;
  logic                err_q;
  logic [ADDR_W:0]     err_cnt_q;

  logic                launch;
  logic                clr_err;
  logic                clr_cnt;
  logic [DATA_W-1:0]   word;
  logic                pipe_vld;
  logic [DATA_W-1:0]   pipe_exp;
  logic                mismatch;

`ifdef RAM_BIST_AUTO_EN
  logic unused_start;
  assign unused_start = start;
  assign launch       = 1'b1;
`else
  assign launch       = start;
`endif

  assign word = DATA_W'(pat(PAT_W'(cnt_q), PAT_W'(DATA_OFS), inv_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ena_d   = 1'b0;
    wea_d   = 1'b0;
    addra_d = addra_q;
    dina_d  = dina_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    rdv_d   = 1'b0;
    rexp_d  = rexp_q;
    inv_d   = inv_q;
    clr_err = 1'b0;
    clr_cnt = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d = ST_WRITE;
          cnt_d   = '0;
`ifndef RAM_BIST_AUTO_EN
          clr_err = 1'b1;
          clr_cnt = 1'b1;
`endif
        end
      end
      ST_WRITE: begin
        ena_d   = 1'b1;
        wea_d   = 1'b1;
        addra_d = cnt_q;
        dina_d  = word;
        busy_d  = 1'b1;
        cnt_d   = cnt_q + ADDR_W'(1);
`ifdef RAM_BIST_AUTO_EN
        // Cleared one edge after DONE so the final compare of the previous
        // pass (which lands on the DONE edge) is still reported with done.
        clr_cnt = (cnt_q == '0);
`endif
        if (cnt_q == LAST_ADDR) state_d = ST_READ;
      end
      ST_READ: begin
        ena_d   = 1'b1;
        addra_d = cnt_q;
        rdv_d   = 1'b1;
        rexp_d  = word;
        busy_d  = 1'b1;
        cnt_d   = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_ADDR) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy_d = 1'b1;
        if (cnt_q == DRAIN_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
`ifdef RAM_BIST_AUTO_EN
        // Skip IDLE so consecutive passes start back-to-back.
        state_d = ST_WRITE;
        cnt_d   = '0;
        inv_d   = ~inv_q;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ena_q   <= 1'b0;
      wea_q   <= 1'b0;
      addra_q <= '0;
      dina_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdv_q   <= 1'b0;
      rexp_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ena_q   <= ena_d;
      wea_q   <= wea_d;
      addra_q <= addra_d;
      dina_q  <= dina_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdv_q   <= rdv_d;
      rexp_q  <= rexp_d;
      inv_q   <= inv_d;
    end
  end

  // rdv_q/rexp_q leave alongside addra, so RD_LAT further stages line up
  // with douta.
  ram_bist_exp_pipe #(
    .DATA_W (DATA_W),
    .DEPTH  (RD_LAT)
  ) u_exp_pipe (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .vld_i  (rdv_q),
    .exp_i  (rexp_q),
    .vld_o  (pipe_vld),
    .exp_o  (pipe_exp)
  );

  assign mismatch = pipe_vld && (douta != pipe_exp);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (clr_err)       err_q <= 1'b0;
      else if (mismatch) err_q <= 1'b1;
      if (clr_cnt)       err_cnt_q <= '0;
      else if (mismatch) err_cnt_q <= err_cnt_q + (ADDR_W+1)'(1);
    end
  end

  assign ena     = ena_q;
  assign wea     = wea_q;
  assign addra   = addra_q;
  assign dina    = dina_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
`timescale 1ns/1ps
module tb_ram_bist_ctrl;
  import ram_bist_pkg::*;

  localparam int unsigned NW = DEPTH;

  typedef struct {
    int         c;
    logic       e;
    logic [5:0] n;
  } done_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // DUT 0: defaults (RD_LAT=1, DATA_OFS=0)
  logic       rst0_n = 1'b0, start0 = 1'b0, stuck0 = 1'b0;
  logic       ena0, wea0, busy0, done0, err0;
  logic [4:0] addra0;
  logic [7:0] dina0, douta0, rd0;
  logic [5:0] errcnt0;
  logic [7:0] mem0 [NW];

  ram_bist_ctrl u_dut0 (
    .sys_clk(clk), .sys_rst_n(rst0_n), .start(start0),
    .ena(ena0), .wea(wea0), .addra(addra0), .dina(dina0), .douta(douta0),
    .busy(busy0), .done(done0), .err(err0), .err_cnt(errcnt0)
  );

  always @(posedge clk) begin
    if (ena0 && wea0)  mem0[addra0] <= dina0;
    if (ena0 && !wea0) rd0 <= mem0[addra0];
  end
  assign douta0 = stuck0 ? (rd0 & 8'hF7) : rd0;

  // DUT 1: two-cycle RAM, offset 0xA5
  logic       rst1_n = 1'b0, start1 = 1'b0;
  logic       ena1, wea1, busy1, done1, err1;
  logic [4:0] addra1;
  logic [7:0] dina1, douta1, rd1a, rd1b;
  logic [5:0] errcnt1;
  logic [7:0] mem1 [NW];

  ram_bist_ctrl #(.RD_LAT(2), .DATA_OFS(8'hA5)) u_dut1 (
    .sys_clk(clk), .sys_rst_n(rst1_n), .start(start1),
    .ena(ena1), .wea(wea1), .addra(addra1), .dina(dina1), .douta(douta1),
    .busy(busy1), .done(done1), .err(err1), .err_cnt(errcnt1)
  );

  always @(posedge clk) begin
    if (ena1 && wea1)  mem1[addra1] <= dina1;
    if (ena1 && !wea1) rd1a <= mem1[addra1];
    rd1b <= rd1a;
  end
  assign douta1 = rd1b;

  // Scoreboards
  logic [12:0] wq0[$], wq1[$];
  done_t       dq0[$], dq1[$];
  done_t       d0, d1;
  int          done_cnt0 = 0, done_cnt1 = 0;
  int          n0, n1;
  logic [12:0] last_wr1 = '0;

  always @(negedge clk) begin
    chk("wea_wo_ena0", {31'd0, wea0 & ~ena0}, 32'd0);
    if (ena0 && wea0) begin
      if (wq0.size() == 0) chk("wr0_extra", 32'd1, 32'd0);
      else chk("wr0", {19'd0, addra0, dina0}, {19'd0, wq0.pop_front()});
    end
    if (done0) begin
      done_cnt0++;
      if (dq0.size() == 0) chk("done0_extra", 32'd1, 32'd0);
      else begin
        d0 = dq0.pop_front();
        chk("done0_cyc", cyc, d0.c);
        chk("done0_err", {25'd0, err0, errcnt0}, {25'd0, d0.e, d0.n});
        chk("done0_busy", {31'd0, busy0}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    chk("wea_wo_ena1", {31'd0, wea1 & ~ena1}, 32'd0);
    if (ena1 && wea1) begin
      last_wr1 = {addra1, dina1};
      if (wq1.size() == 0) chk("wr1_extra", 32'd1, 32'd0);
      else chk("wr1", {19'd0, addra1, dina1}, {19'd0, wq1.pop_front()});
    end
    if (done1) begin
      done_cnt1++;
      if (dq1.size() == 0) chk("done1_extra", 32'd1, 32'd0);
      else begin
        d1 = dq1.pop_front();
        chk("done1_cyc", cyc, d1.c);
        chk("done1_err", {25'd0, err1, errcnt1}, {25'd0, d1.e, d1.n});
      end
    end
  end

  // Pulses start for one cycle; the pass's start edge is the next posedge.
  task automatic launch0(input logic e, input logic [5:0] n);
    @(negedge clk);
    start0 = 1'b1;
    n0 = cyc + 1;
    for (int a = 0; a < NW; a++) wq0.push_back({5'(a), 8'(a)});
    dq0.push_back('{c: n0 + 66, e: e, n: n});
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic launch1();
    @(negedge clk);
    start1 = 1'b1;
    n1 = cyc + 1;
    for (int a = 0; a < NW; a++) wq1.push_back({5'(a), 8'(a + 8'hA5)});
    dq1.push_back('{c: n1 + 67, e: 1'b0, n: 6'd0});
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic wait_done0(input int target);
    for (int i = 0; i < 300 && done_cnt0 < target; i++) @(negedge clk);
    chk("done0_wait", done_cnt0, target);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_outs0", {10'd0, ena0, wea0, addra0, dina0, busy0, done0, err0, errcnt0}, 32'd0);
    chk("rst_outs1", {10'd0, ena1, wea1, addra1, dina1, busy1, done1, err1, errcnt1}, 32'd0);
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_outs0", {10'd0, ena0, wea0, addra0, dina0, busy0, done0, err0, errcnt0}, 32'd0);

    // Clean pass, check first-write latency
    launch0(1'b0, 6'd0);
    chk("wr_lat0", {31'd0, ena0}, 32'd0);
    @(negedge clk);
    chk("first_wr0", {24'd0, ena0, wea0, busy0, addra0}, {24'd0, 3'b111, 5'd0});
    wait_done0(1);

    // douta[3] stuck at 0: 16 of 32 words mismatch
    stuck0 = 1'b1;
    launch0(1'b1, 6'd16);
    wait_done0(2);
    repeat (5) @(negedge clk);
    chk("err_hold0", {25'd0, err0, errcnt0}, {25'd0, 1'b1, 6'd16});
    stuck0 = 1'b0;

    // Starts while busy are ignored
    launch0(1'b0, 6'd0);
    @(negedge clk);
    chk("err_clr0", {25'd0, err0, errcnt0}, 32'd0);
    while (cyc < n0 + 9) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    while (cyc < n0 + 39) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done0(3);
    repeat (30) @(negedge clk);
    chk("one_done0", done_cnt0, 3);

    // Asynchronous reset in the middle of READ
    launch0(1'b0, 6'd0);
    for (int i = 0; i < 200; i++) begin
      if (ena0 && !wea0 && addra0 == 5'd10) break;
      @(negedge clk);
    end
    chk("rd10_seen0", {25'd0, ena0, wea0, addra0}, {25'd0, 1'b1, 1'b0, 5'd10});
    #2 rst0_n = 1'b0;
    #1 chk("async_rst0", {28'd0, ena0, wea0, busy0, done0}, 32'd0);
    dq0.delete();
    repeat (3) @(negedge clk);
    rst0_n = 1'b1;
    repeat (80) @(negedge clk);
    chk("no_done_rst0", done_cnt0, 3);
    launch0(1'b0, 6'd0);
    wait_done0(4);

    // RD_LAT=2, DATA_OFS=0xA5
    launch1();
    for (int i = 0; i < 300 && done_cnt1 < 1; i++) @(negedge clk);
    chk("done1_wait", done_cnt1, 1);
    chk("dina1_1F", {19'd0, last_wr1}, {19'd0, 5'h1F, 8'hC4});

    repeat (5) @(negedge clk);
    chk("wq_empty", wq0.size() + wq1.size() + dq0.size() + dq1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
